// File: rtl/gpio_in_port.sv
// rtl/gpio_in_port.sv - 8-bit debounced GPIO input port with edge status and interrupt
module gpio_in_port #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0800,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  gpio_i,
    input  logic [31:0] data_addr,
    input  logic        datamem_rd,
    input  logic        datamem_wr,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        irq
);

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] SEL_DATA   = 2'd0;
    localparam logic [1:0] SEL_STATUS = 2'd1;
    localparam logic [1:0] SEL_IRQ_EN = 2'd2;
    localparam logic [1:0] SEL_RAW    = 2'd3;

    logic [7:0] sync1;
    logic [7:0] sync2;
    logic [7:0] debounced;
    logic [7:0] status;
    logic [7:0] irq_en;
    logic [7:0] cnt [8];

    logic       hit;
    logic [1:0] sel;
    logic [7:0] db_load;
    logic [7:0] db_next;
    logic [7:0] rise;
    logic [7:0] clear_mask;
    logic [7:0] rd_mux;
    logic       unused_bits;

    // Address byte offset and upper write-data bits carry no information here.
    assign unused_bits = ^{data_addr[1:0], data_wr[31:8]};

    // Register window decode on the 16-byte aligned base.
    always_comb begin
        hit = (data_addr[31:4] == BASE_ADDR[31:4]);
        sel = data_addr[3:2];
    end

    // Two-flop synchronizer for the asynchronous pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 8'h00;
            sync2 <= 8'h00;
        end else begin
            sync1 <= gpio_i;
            sync2 <= sync1;
        end
    end

    // A bit is accepted once it has differed from the debounced value for the full window.
    always_comb begin
        db_load = 8'h00;
        for (int i = 0; i < 8; i++) begin
            db_load[i] = (sync2[i] != debounced[i]) && (cnt[i] == CNT_MAX);
        end
        db_next = (debounced & ~db_load) | (sync2 & db_load);
        rise    = db_load & sync2;
    end

    // Per-bit stability counters; any agreement with the debounced value restarts the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (sync2[i] == debounced[i] || cnt[i] == CNT_MAX) begin
                    cnt[i] <= 8'h00;
                end else begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    // Debounced input state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            debounced <= 8'h00;
        end else begin
            debounced <= db_next;
        end
    end

    // Write-1-to-clear mask for STATUS; only a hit write to the STATUS slot clears.
    always_comb begin
        clear_mask = 8'h00;
        if (hit && datamem_wr && sel == SEL_STATUS) begin
            clear_mask = data_wr[7:0];
        end
    end

    // Rising-edge flags; a fresh rising edge beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status <= 8'h00;
        end else begin
            status <= (status & ~clear_mask) | rise;
        end
    end

    // Interrupt enable register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en <= 8'h00;
        end else if (hit && datamem_wr && sel == SEL_IRQ_EN) begin
            irq_en <= data_wr[7:0];
        end
    end

    // Read mux over pre-write register values.
    always_comb begin
        rd_mux = 8'h00;
        case (sel)
            SEL_DATA:   rd_mux = debounced;
            SEL_STATUS: rd_mux = status;
            SEL_IRQ_EN: rd_mux = irq_en;
            SEL_RAW:    rd_mux = sync2;
            default:    rd_mux = 8'h00;
        endcase
    end

    // Registered read data and interrupt level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_rd <= 32'h0;
            irq     <= 1'b0;
        end else begin
            data_rd <= (hit && datamem_rd) ? {24'h0, rd_mux} : 32'h0;
            irq     <= |(status & irq_en);
        end
    end

endmodule

// File: tb/tb_gpio_in_port.sv
// tb/tb_gpio_in_port.sv - self-checking bench for gpio_in_port
module tb_gpio_in_port;

    localparam logic [31:0] BASE = 32'h0000_0800;
    localparam int          DEB  = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  gpio_i;
    logic [31:0] data_addr;
    logic        datamem_rd;
    logic        datamem_wr;
    logic [31:0] data_wr;
    logic [31:0] data_rd;
    logic        irq;

    int checks = 0;
    int errors = 0;

    gpio_in_port #(
        .BASE_ADDR(BASE),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .gpio_i(gpio_i),
        .data_addr(data_addr),
        .datamem_rd(datamem_rd),
        .datamem_wr(datamem_wr),
        .data_wr(data_wr),
        .data_rd(data_rd),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pins seen two edges late, a level is accepted once the
    // last DEB pre-edge samples all agree on a value different from the accepted one.
    logic [7:0]  m_p1, m_p2, m_db, m_status, m_en;
    logic [7:0]  m_hist [DEB];
    logic [31:0] m_data_rd;
    logic        m_irq;

    always @(posedge clk or posedge rst) begin : model
        logic [7:0] all1, all0, nd, rise, clr, val;
        logic       hit;
        if (rst) begin
            m_p1 <= 8'h00; m_p2 <= 8'h00; m_db <= 8'h00;
            m_status <= 8'h00; m_en <= 8'h00;
            m_data_rd <= 32'h0; m_irq <= 1'b0;
            for (int k = 0; k < DEB; k++) m_hist[k] <= 8'h00;
        end else begin
            all1 = m_p2;
            all0 = ~m_p2;
            for (int k = 0; k < DEB - 1; k++) begin
                all1 = all1 & m_hist[k];
                all0 = all0 & ~m_hist[k];
            end
            nd   = (m_db | all1) & ~all0;
            rise = nd & ~m_db;
            hit  = (data_addr >> 4) == (BASE >> 4);
            clr  = (hit && datamem_wr && data_addr[3:2] == 2'd1) ? data_wr[7:0] : 8'h00;
            case (data_addr[3:2])
                2'd0:    val = m_db;
                2'd1:    val = m_status;
                2'd2:    val = m_en;
                default: val = m_p2;
            endcase
            m_data_rd <= (hit && datamem_rd) ? {24'h0, val} : 32'h0;
            m_irq     <= |(m_status & m_en);
            m_status  <= (m_status & ~clr) | rise;
            if (hit && datamem_wr && data_addr[3:2] == 2'd2) m_en <= data_wr[7:0];
            m_db      <= nd;
            m_hist[0] <= m_p2;
            for (int k = 1; k < DEB; k++) m_hist[k] <= m_hist[k-1];
            m_p2 <= m_p1;
            m_p1 <= gpio_i;
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model_data_rd", data_rd, m_data_rd);
        chk("model_irq", {31'h0, irq}, {31'h0, m_irq});
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        data_addr  = a;
        datamem_rd = 1'b1;
        @(negedge clk);
        datamem_rd = 1'b0;
        chk(name, data_rd, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        data_addr  = a;
        data_wr    = d;
        datamem_wr = 1'b1;
        @(negedge clk);
        datamem_wr = 1'b0;
    endtask

    task automatic rw(input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp, input string name);
        data_addr  = a;
        data_wr    = d;
        datamem_wr = 1'b1;
        datamem_rd = 1'b1;
        @(negedge clk);
        datamem_wr = 1'b0;
        datamem_rd = 1'b0;
        chk(name, data_rd, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; gpio_i = 8'h00; data_addr = 32'h0;
        datamem_rd = 1'b0; datamem_wr = 1'b0; data_wr = 32'h0;
        cycles(2);
        chk("reset_data_rd", data_rd, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        rst = 1'b0;
        cycles(2);
        rd(BASE + 32'h0, 32'h0, "reset_data");
        rd(BASE + 32'h4, 32'h0, "reset_status");
        rd(BASE + 32'h8, 32'h0, "reset_irq_en");
        rd(BASE + 32'hC, 32'h0, "reset_raw");

        // Single bit rising with interrupt enabled
        wr(BASE + 32'h8, 32'h01);
        gpio_i = 8'h01;
        cycles(1);
        rd(BASE + 32'hC, 32'h00, "raw_before_2");
        rd(BASE + 32'hC, 32'h01, "raw_after_2");
        rd(BASE + 32'h0, 32'h00, "data_e4");
        rd(BASE + 32'h0, 32'h00, "data_e5");
        rd(BASE + 32'h0, 32'h00, "data_e6_pre");
        chk("irq_before", {31'h0, irq}, 32'h0);
        rd(BASE + 32'h0, 32'h01, "data_after_6");
        chk("irq_after", {31'h0, irq}, 32'h1);
        rd(BASE + 32'h4, 32'h01, "status_after_6");

        // Three-cycle glitch on bit 3 is rejected
        gpio_i = 8'h09;
        cycles(3);
        gpio_i = 8'h01;
        cycles(8);
        rd(BASE + 32'h0, 32'h01, "glitch_data");
        rd(BASE + 32'h4, 32'h01, "glitch_status");

        // W1C of bit 2 with bit 0 enabled
        gpio_i = 8'h05;
        cycles(8);
        rd(BASE + 32'h4, 32'h05, "status_05");
        wr(BASE + 32'h4, 32'h04);
        rd(BASE + 32'h4, 32'h01, "status_after_w1c");
        chk("irq_kept", {31'h0, irq}, 32'h1);

        // W1C of the only enabled flag drops irq one cycle after the write
        gpio_i = 8'h01;
        cycles(8);
        gpio_i = 8'h05;
        cycles(8);
        rd(BASE + 32'h4, 32'h05, "status_05_again");
        wr(BASE + 32'h8, 32'h04);
        cycles(2);
        chk("irq_en4_high", {31'h0, irq}, 32'h1);
        wr(BASE + 32'h4, 32'h04);
        chk("irq_write_edge", {31'h0, irq}, 32'h1);
        cycles(1);
        chk("irq_dropped", {31'h0, irq}, 32'h0);

        // W1C on the same edge bit 1 debounces high: the set wins
        gpio_i = 8'h07;
        cycles(5);
        wr(BASE + 32'h4, 32'h02);
        rd(BASE + 32'h4, 32'h03, "w1c_vs_rise");

        // Register access corners
        wr(BASE + 32'h8, 32'hFFFF_FFA5);
        rd(BASE + 32'h8, 32'hA5, "irq_en_a5");
        rd(32'h900, 32'h0, "miss_read");
        rd(BASE + 32'hB, 32'hA5, "byte_offset_ignored");
        wr(32'h908, 32'h0);
        wr(BASE + 32'h0, 32'hFF);
        wr(BASE + 32'hC, 32'hFF);
        rd(BASE + 32'h8, 32'hA5, "ignored_writes");
        rd(BASE + 32'h0, 32'h07, "data_ro");
        rd(BASE + 32'hC, 32'h07, "raw_ro");
        rw(BASE + 32'h8, 32'h3C, 32'hA5, "rd_wr_prewrite");
        rd(BASE + 32'h8, 32'h3C, "rd_wr_after");

        // Reset mid-debounce
        wr(BASE + 32'h8, 32'hFF);
        gpio_i     = 8'h10;
        data_addr  = BASE;
        datamem_rd = 1'b1;
        cycles(3);
        chk("pre_rst_data_rd", data_rd, 32'h07);
        chk("pre_rst_irq", {31'h0, irq}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_data_rd", data_rd, 32'h0);
        chk("async_rst_irq", {31'h0, irq}, 32'h0);
        datamem_rd = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(5);
        rd(BASE + 32'h0, 32'h00, "post_rst_data_e6_pre");
        rd(BASE + 32'h0, 32'h10, "post_rst_data");
        rd(BASE + 32'h4, 32'h10, "post_rst_status");

        // All-ones pins after reset
        gpio_i = 8'hFF;
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(5);
        rd(BASE + 32'h0, 32'h00, "ff_data_e6_pre");
        rd(BASE + 32'h0, 32'hFF, "ff_data");
        rd(BASE + 32'h4, 32'hFF, "ff_status");
        chk("ff_irq", {31'h0, irq}, 32'h0);

        cycles(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_in_port.md
GPIO_IN_PORT -- requirements
Module: gpio_in_port

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0800, data-bus base address of the 16-byte register window.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, stable cycles required before an input change is accepted (legal 2..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port gpio_i  input  8  external pins, asynchronous to clk.
REQ-006 SHALL have port data_addr  input  32  CPU data address.
REQ-007 SHALL have port datamem_rd  input  1  CPU read strobe, one cycle per access.
REQ-008 SHALL have port datamem_wr  input  1  CPU write strobe, one cycle per access.
REQ-009 SHALL have port data_wr  input  32  CPU write data.
REQ-010 SHALL have port data_rd  output  32  registered read data.
REQ-011 SHALL have port irq  output  1  registered level interrupt request.

Function
REQ-012 SHALL decode a hit when data_addr[31:4] == BASE_ADDR[31:4]; data_addr[3:2] selects the register; data_addr[1:0] is ignored.
REQ-013 SHALL implement registers: 0x0 DATA (RO, debounced inputs), 0x4 STATUS (rising-edge flags, write-1-to-clear), 0x8 IRQ_EN (RW, bits [7:0]), 0xC RAW (RO, synchronizer output).
REQ-014 SHALL pass each gpio_i bit through a two-flop synchronizer; RAW reflects the second flop.
REQ-015 SHALL keep a per-bit counter: clear when sync bit equals debounced bit; otherwise increment; when the counter equals DEBOUNCE_CYCLES-1 and the bits still differ, load the debounced bit from sync and clear the counter on the same edge.
REQ-016 SHALL update the debounced bit DEBOUNCE_CYCLES cycles after the sync bit changes and stays changed; a glitch shorter than that leaves the debounced bit unchanged.
REQ-017 SHALL set STATUS[n] on the same edge that debounced bit n goes 0->1; falling edges do not set status.
REQ-018 SHALL clear STATUS[n] on a hit write to 0x4 with data_wr[n]=1; on the same edge, a new rising edge on bit n takes priority and leaves STATUS[n]=1.
REQ-019 SHALL ignore writes to 0x0 and 0xC, and writes while not hit.
REQ-020 SHALL load data_rd one edge after a cycle with datamem_rd=1 and a hit, with the selected register zero-extended to 32 bits; otherwise data_rd SHALL be 0 on that edge.
REQ-021 SHALL, on simultaneous datamem_rd and datamem_wr to the same register, return the pre-write value.
REQ-022 SHALL drive irq registered as OR-reduce(STATUS & IRQ_EN), one cycle after the contributing state changes.
REQ-023 SHALL ignore data_wr[31:8] for all registers.

Reset
REQ-024 SHALL, while rst=1, asynchronously clear synchronizer flops, debounced bits, counters, STATUS, IRQ_EN, data_rd and irq to 0.
REQ-025 SHALL, after rst deasserts with gpio_i=8'hFF, treat all bits as rising changes; the debounced bits go to 1 and the STATUS bits are set after 2+DEBOUNCE_CYCLES cycles.
REQ-026 SHALL, when rst asserts mid-debounce, discard the partial count; no STATUS bit is set from that partial count.

Verification (DEBOUNCE_CYCLES=4, BASE_ADDR=32'h800)
REQ-027 SHALL cover: gpio_i 00->01 held 10 cycles -> RAW=01 after 2 cycles; DATA=01 and STATUS=01 after 6 cycles; with IRQ_EN=01, irq=1 one cycle later.
REQ-028 SHALL cover: gpio_i[3] pulsed high for 3 cycles -> DATA and STATUS unchanged (0); irq stays 0.
REQ-029 SHALL cover: STATUS=0x05, write 0x804 data 0x04 -> STATUS=0x01; irq stays 1 if IRQ_EN[0]=1, else irq drops one cycle after the write.
REQ-030 SHALL cover: W1C of bit 1 on the same edge bit 1 debounces high -> STATUS[1]=1.
REQ-031 SHALL cover: read 0x808 after writing IRQ_EN=0xA5 -> data_rd=32'h0000_00A5 one cycle after datamem_rd; a read of 0x900 -> data_rd=0.
REQ-032 SHALL cover: rst asserted mid-debounce with gpio_i=0x10 -> all outputs 0 immediately; after release, DATA=0x10 after 6 cycles.
